// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Paces the PC register, instruction memory request and IF/ID
//               latch; handles boot delay, stalls, redirects and halt.
// Revision    : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_pcsrc,
    input  logic             hazard_stall,
    input  logic             halt,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             if_id_we,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [2:0] S_BOOT     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_STALL    = 3'd2;
    localparam logic [2:0] S_REDIRECT = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] boot_cnt;
    logic [2:0] flush_cnt;
    logic [2:0] flush_cnt_next;
    logic       redirect;
    logic       advance;

    // Priority: redirect, then halt, then hazard, then a normal fetch.
    always_comb begin
        next_state = state;
        redirect   = 1'b0;
        advance    = 1'b0;
        case (state)
            S_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ex_mem_pcsrc) begin
                    redirect   = 1'b1;
                    next_state = S_REDIRECT;
                end else if (halt) begin
                    next_state = S_HALT;
                end else if (hazard_stall) begin
                    next_state = S_STALL;
                end else if (imem_ready) begin
                    advance    = 1'b1;
                end
            end
            S_STALL: begin
                if (ex_mem_pcsrc) begin
                    redirect   = 1'b1;
                    next_state = S_REDIRECT;
                end else if (halt) begin
                    next_state = S_HALT;
                end else if (!hazard_stall) begin
                    next_state = S_FETCH;
                end
            end
            S_REDIRECT: begin
                if (ex_mem_pcsrc) begin
                    redirect   = 1'b1;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_BOOT;
            end
        endcase
    end

    always_comb begin
        flush_cnt_next = flush_cnt;
        if (redirect) begin
            flush_cnt_next = FLUSH_LOAD;
        end else if (flush_cnt != 3'd0) begin
            flush_cnt_next = flush_cnt - 3'd1;
        end
    end

    // Gated by reset so the datapath enables drop the moment reset asserts.
    assign pc_we    = rst & (redirect | advance);
    assign pc_sel   = rst & redirect;
    assign if_id_we = rst & advance;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            boot_cnt    <= 4'd0;
            flush_cnt   <= 3'd0;
            imem_req    <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= flush_cnt_next;
            flush     <= (flush_cnt_next != 3'd0);
            imem_req  <= (next_state == S_FETCH) || (next_state == S_STALL);
            halted    <= (next_state == S_HALT);
            if (state == S_BOOT && next_state == S_BOOT) begin
                boot_cnt <= boot_cnt + 4'd1;
            end else begin
                boot_cnt <= 4'd0;
            end
            if (advance) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int BOOT_CYCLES  = 2;
    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ex_mem_pcsrc = 1'b0;
    logic             hazard_stall = 1'b0;
    logic             halt = 1'b0;
    logic             imem_ready = 1'b0;
    logic             imem_req;
    logic             pc_we;
    logic             pc_sel;
    logic             if_id_we;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .BOOT_CYCLES  (BOOT_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_pcsrc (ex_mem_pcsrc),
        .hazard_stall (hazard_stall),
        .halt         (halt),
        .imem_ready   (imem_ready),
        .imem_req     (imem_req),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .if_id_we     (if_id_we),
        .flush        (flush),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_en(input string tag, input logic we, input logic sel, input logic ifid);
        check_eq({tag, "_pc_we"}, {31'd0, pc_we}, {31'd0, we});
        check_eq({tag, "_pc_sel"}, {31'd0, pc_sel}, {31'd0, sel});
        check_eq({tag, "_if_id_we"}, {31'd0, if_id_we}, {31'd0, ifid});
    endtask

    initial begin
        // Reset held with inputs that would otherwise fire enables.
        tick();
        tick();
        imem_ready   = 1'b1;
        ex_mem_pcsrc = 1'b1;
        settle();
        check_en("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("reset_flush", {31'd0, flush}, 32'd0);
        check_eq("reset_halted", {31'd0, halted}, 32'd0);
        check_eq("reset_count", {16'd0, fetch_count}, 32'd0);

        // Release; BOOT must ignore redirect, halt and hazard.
        rst          = 1'b1;
        halt         = 1'b1;
        hazard_stall = 1'b1;
        settle();
        check_en("boot0", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("boot1_imem_req", {31'd0, imem_req}, 32'd0);
        settle();
        check_en("boot1", 1'b0, 1'b0, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        halt         = 1'b0;
        hazard_stall = 1'b0;
        check_eq("first_req", {31'd0, imem_req}, 32'd1);
        check_eq("first_req_halted", {31'd0, halted}, 32'd0);
        check_eq("first_req_flush", {31'd0, flush}, 32'd0);
        check_eq("first_req_count", {16'd0, fetch_count}, 32'd0);
        settle();
        check_en("fetch0", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stream_pc_we", {31'd0, pc_we}, 32'd1);
        end
        tick();
        check_eq("count_after5", {16'd0, fetch_count}, 32'd5);

        // Memory not ready for three cycles.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_en("wait_mem", 1'b0, 1'b0, 1'b0);
            tick();
        end
        imem_ready = 1'b1;
        settle();
        check_en("mem_ready", 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("count_after_wait", {16'd0, fetch_count}, 32'd6);

        // Redirect with hazard and ready also high: redirect wins.
        ex_mem_pcsrc = 1'b1;
        hazard_stall = 1'b1;
        settle();
        check_en("redir", 1'b1, 1'b1, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        hazard_stall = 1'b0;
        check_eq("redir_req_drop", {31'd0, imem_req}, 32'd0);
        check_eq("redir_flush1", {31'd0, flush}, 32'd1);
        check_eq("redir_count", {16'd0, fetch_count}, 32'd6);
        settle();
        check_en("redir_state", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("resume_req", {31'd0, imem_req}, 32'd1);
        check_eq("redir_flush2", {31'd0, flush}, 32'd1);
        check_eq("resume_count", {16'd0, fetch_count}, 32'd6);
        tick();
        check_eq("redir_flush3", {31'd0, flush}, 32'd1);
        check_eq("resume_count1", {16'd0, fetch_count}, 32'd7);
        tick();
        check_eq("redir_flush_end", {31'd0, flush}, 32'd0);
        check_eq("resume_count2", {16'd0, fetch_count}, 32'd8);

        // Hazard held four cycles, redirect in the second.
        hazard_stall = 1'b1;
        settle();
        check_en("haz1", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("stall_req", {31'd0, imem_req}, 32'd1);
        ex_mem_pcsrc = 1'b1;
        settle();
        check_en("haz2_redir", 1'b1, 1'b1, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        check_eq("haz3_req", {31'd0, imem_req}, 32'd0);
        check_eq("haz3_flush", {31'd0, flush}, 32'd1);
        settle();
        check_en("haz3", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("haz4_req", {31'd0, imem_req}, 32'd1);
        settle();
        check_en("haz4", 1'b0, 1'b0, 1'b0);
        tick();
        hazard_stall = 1'b0;
        settle();
        check_en("stall_exit", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("haz_count", {16'd0, fetch_count}, 32'd8);
        settle();
        check_en("haz_refetch", 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("haz_count2", {16'd0, fetch_count}, 32'd9);

        // Back-to-back redirects.
        ex_mem_pcsrc = 1'b1;
        settle();
        check_en("dbl1", 1'b1, 1'b1, 1'b0);
        tick();
        settle();
        check_en("dbl2", 1'b1, 1'b1, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        check_eq("dbl_req", {31'd0, imem_req}, 32'd0);
        check_eq("dbl_flush", {31'd0, flush}, 32'd1);
        tick();
        check_eq("dbl_resume", {31'd0, imem_req}, 32'd1);
        check_eq("dbl_count", {16'd0, fetch_count}, 32'd9);
        tick();
        check_eq("dbl_flush_d", {31'd0, flush}, 32'd1);
        tick();
        check_eq("dbl_flush_e", {31'd0, flush}, 32'd0);
        check_eq("dbl_count2", {16'd0, fetch_count}, 32'd11);

        // Halt together with hazard.
        halt         = 1'b1;
        hazard_stall = 1'b1;
        settle();
        check_en("halt_cyc", 1'b0, 1'b0, 1'b0);
        tick();
        halt         = 1'b0;
        hazard_stall = 1'b0;
        check_eq("halted", {31'd0, halted}, 32'd1);
        check_eq("halt_req", {31'd0, imem_req}, 32'd0);
        check_eq("halt_count", {16'd0, fetch_count}, 32'd11);
        ex_mem_pcsrc = 1'b1;
        settle();
        check_en("halt_redir", 1'b0, 1'b0, 1'b0);
        tick();
        ex_mem_pcsrc = 1'b0;
        check_eq("halted_hold", {31'd0, halted}, 32'd1);
        check_eq("halt_flush", {31'd0, flush}, 32'd0);

        // Asynchronous reset out of HALT.
        rst = 1'b0;
        #1;
        check_eq("async_halted", {31'd0, halted}, 32'd0);
        check_eq("async_count", {16'd0, fetch_count}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_eq("reboot_req", {31'd0, imem_req}, 32'd1);
        settle();
        check_en("reboot_fetch", 1'b1, 1'b0, 1'b1);

        // Asynchronous reset while fetching.
        rst = 1'b0;
        #1;
        check_en("async_fetch", 1'b0, 1'b0, 1'b0);
        check_eq("async_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_eq("wrap_start", {16'd0, fetch_count}, 32'd0);

        // Counter wrap.
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check_eq("count_ffff", {16'd0, fetch_count}, 32'h0000_ffff);
        tick();
        check_eq("count_wrap", {16'd0, fetch_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
